// File: rtl/i2c_scl_phase_gen.sv
// i2c_scl_phase_gen: quarter-phase SCL generator with slave clock stretching and stretch timeout
module i2c_scl_phase_gen #(
    parameter int SYS_CLK     = 100000000,
    parameter int DIV_WIDTH   = 16,
    parameter int STRETCH_MAX = 100000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [1:0]           mode,
    input  logic [DIV_WIDTH-1:0] custom_q,
    input  logic                 scl_in,
    output logic                 scl_oe,
    output logic [1:0]           phase,
    output logic                 fall_tick,
    output logic                 change_tick,
    output logic                 rise_tick,
    output logic                 sample_tick,
    output logic                 period_done,
    output logic                 busy,
    output logic                 stretching,
    output logic                 stretch_timeout
);
    localparam int WW = ($clog2(STRETCH_MAX + 1) < 1) ? 1 : $clog2(STRETCH_MAX + 1);
    localparam logic [WW-1:0]        WAIT_MAX = WW'(STRETCH_MAX);
    localparam logic [DIV_WIDTH-1:0] Q_STD    = DIV_WIDTH'(SYS_CLK / 400000);
    localparam logic [DIV_WIDTH-1:0] Q_FAST   = DIV_WIDTH'(SYS_CLK / 1600000);
    localparam logic [DIV_WIDTH-1:0] Q_FMP    = DIV_WIDTH'(SYS_CLK / 4000000);
    localparam logic [DIV_WIDTH-1:0] Q_MIN    = DIV_WIDTH'(2);
    localparam logic [DIV_WIDTH-1:0] ONE      = DIV_WIDTH'(1);

    typedef enum logic [2:0] {IDLE, LOW_A, LOW_B, HIGH_A, HIGH_B} state_t;

    state_t               state_q, state_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d, qlen_q, qlen_d, q_sel;
    logic [WW-1:0]        wait_q, wait_d;
    logic [1:0]           sync_q, sync_d;
    logic [3:0]           tick_q, tick_d;
    logic                 oe_q, oe_d, load, timeout, scl_sync, cnt_zero;

    assign scl_sync = sync_q[1];
    assign cnt_zero = cnt_q == '0;
    assign q_sel    = mode == 2'd0 ? Q_STD :
                      mode == 2'd1 ? Q_FAST :
                      mode == 2'd2 ? Q_FMP :
                      custom_q < Q_MIN ? Q_MIN : custom_q;

    // Next-state logic: quarter counting, stretch wait, timeout, and period restart
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_zero ? qlen_q - ONE : cnt_q - ONE;
        qlen_d  = qlen_q;
        wait_d  = '0;
        tick_d  = '0;
        load    = 1'b0;
        timeout = 1'b0;
        sync_d  = {sync_q[0], scl_in};
        case (state_q)
            IDLE: begin
                cnt_d = cnt_q;
                load  = enable;
            end
            LOW_A: if (cnt_zero) begin
                state_d = LOW_B;
                tick_d  = 4'b0010;
            end
            LOW_B: if (cnt_zero) begin
                state_d = HIGH_A;
                tick_d  = 4'b0100;
            end
            HIGH_A: if (scl_sync) begin
                if (cnt_zero) begin
                    state_d = HIGH_B;
                    tick_d  = 4'b1000;
                end
            end else begin
                cnt_d   = cnt_q;
                timeout = STRETCH_MAX != 0 && wait_q == WAIT_MAX;
                state_d = timeout ? IDLE : HIGH_A;
                wait_d  = wait_q == WAIT_MAX ? wait_q : wait_q + 1'b1;
            end
            HIGH_B: if (cnt_zero) begin
                state_d = IDLE;
                load    = enable;
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            state_d = LOW_A;
            qlen_d  = q_sel;
            cnt_d   = q_sel - ONE;
            tick_d  = 4'b0001;
        end
        oe_d = state_d == LOW_A || state_d == LOW_B;
    end

    // State registers; synchroniser idles high so a released bus reads as high
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            qlen_q  <= Q_MIN;
            wait_q  <= '0;
            sync_q  <= 2'b11;
            tick_q  <= '0;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            qlen_q  <= qlen_d;
            wait_q  <= wait_d;
            sync_q  <= sync_d;
            tick_q  <= tick_d;
            oe_q    <= oe_d;
        end
    end

    assign scl_oe          = oe_q;
    assign phase           = state_q == LOW_B ? 2'd1 : state_q == HIGH_A ? 2'd2 : state_q == HIGH_B ? 2'd3 : 2'd0;
    assign {sample_tick, rise_tick, change_tick, fall_tick} = tick_q;
    assign period_done     = state_q == HIGH_B && cnt_zero;
    assign busy            = state_q != IDLE;
    assign stretching      = state_q == HIGH_A && !scl_sync;
    assign stretch_timeout = timeout;
endmodule

// File: tb/tb_i2c_scl_phase_gen.sv
// tb_i2c_scl_phase_gen: scoreboard bench measuring every SCL quarter against a phase-length model
`timescale 1ns/1ps
module tb_i2c_scl_phase_gen;
    localparam int SM = 64;

    typedef struct {int ph; int len; int str; int to;} exp_t;

    logic        clk, reset, enable, scl_in;
    logic [1:0]  mode;
    logic [15:0] custom_q;
    logic        scl_oe, fall_tick, change_tick, rise_tick, sample_tick;
    logic        period_done, busy, stretching, stretch_timeout;
    logic [1:0]  phase;

    exp_t exp_q[$];
    int   sq[$];
    int   hold_left = 0;
    int   checks = 0, errors = 0;
    int   cyc = 0, open_ph = -1, start = 0, str_cnt = 0, to_cnt = 0, pd_cyc = -10;

    i2c_scl_phase_gen #(.SYS_CLK(100000000), .DIV_WIDTH(16), .STRETCH_MAX(SM)) dut (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .custom_q(custom_q),
        .scl_in(scl_in), .scl_oe(scl_oe), .phase(phase), .fall_tick(fall_tick),
        .change_tick(change_tick), .rise_tick(rise_tick), .sample_tick(sample_tick),
        .period_done(period_done), .busy(busy), .stretching(stretching),
        .stretch_timeout(stretch_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign scl_in = ~scl_oe & (hold_left == 0);

    task automatic chk(input string n, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", n, a, e);
        end
    endtask

    function automatic int qof(input int m, input int c);
        case (m)
            0: return 100000000 / 400000;
            1: return 100000000 / 1600000;
            2: return 100000000 / 4000000;
            default: return c < 2 ? 2 : c;
        endcase
    endfunction

    task automatic push_period(input int q, input int s);
        exp_q.push_back('{0, q, 0, 0});
        exp_q.push_back('{1, q, 0, 0});
        if (s + 2 > SM) exp_q.push_back('{2, SM + 1, SM + 1, 1});
        else begin
            exp_q.push_back('{2, q + 2 + s, s + 2, 0});
            exp_q.push_back('{3, q, 0, 0});
        end
        sq.push_back(s);
    endtask

    task automatic wait_sig(input int which, input int lim);
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if ((which == 0 && change_tick) || (which == 1 && !busy) || (which == 2 && rise_tick)) return;
        end
        chk($sformatf("wait_expired_%0d", which), 0, 1);
    endtask

    task automatic run(input int n, input int ms[8], input int cs[8], input int ss[8]);
        mode = 2'(ms[0]);
        custom_q = 16'(cs[0]);
        push_period(qof(ms[0], cs[0]), ss[0]);
        enable = 1'b1;
        @(negedge clk);
        chk("start_latency", int'(fall_tick), 1);
        for (int k = 0; k < n; k++) begin
            wait_sig(0, 5000);
            if (k == n - 1 || ss[k] + 2 > SM) begin
                enable = 1'b0;
                break;
            end
            mode = 2'(ms[k + 1]);
            custom_q = 16'(cs[k + 1]);
            push_period(qof(ms[k + 1], cs[k + 1]), ss[k + 1]);
        end
        wait_sig(1, 5000);
        repeat (3) @(negedge clk);
    endtask

    task automatic reset_test(input int q);
        mode = 2'd3;
        custom_q = 16'(q);
        exp_q.push_back('{0, q, 0, 0});
        exp_q.push_back('{1, q, 0, 0});
        exp_q.push_back('{2, 1, 1, 0});
        sq.push_back(0);
        enable = 1'b1;
        wait_sig(2, 1000);
        reset = 1'b1;
        push_period(q, 0);
        @(negedge clk);
        chk("reset_outputs", int'({scl_oe, phase, fall_tick, change_tick, rise_tick, sample_tick,
            period_done, busy, stretching, stretch_timeout}), 0);
        reset = 1'b0;
        wait_sig(0, 1000);
        enable = 1'b0;
        wait_sig(1, 1000);
        repeat (3) @(negedge clk);
    endtask

    // Slave model: holds SCL low for the queued number of cycles after each rise
    always @(negedge clk) begin
        if (rise_tick === 1'b1) hold_left <= sq.size() > 0 ? sq.pop_front() : 0;
        else if (hold_left > 0) hold_left <= hold_left - 1;
    end

    // Monitor: measures each quarter from its tick to the next tick or to idle, then scores it
    always @(negedge clk) begin : mon
        logic [3:0] tv;
        int idx;
        exp_t e;
        cyc++;
        tv = {sample_tick, rise_tick, change_tick, fall_tick};
        if (open_ph >= 0 && (tv != 0 || !busy)) begin
            if (exp_q.size() == 0) chk($sformatf("unexpected_phase%0d@%0d", open_ph, cyc), 1, 0);
            else begin
                e = exp_q.pop_front();
                chk($sformatf("phase_id@%0d", cyc), open_ph, e.ph);
                chk($sformatf("phase_len%0d@%0d", e.ph, cyc), cyc - start, e.len);
                chk($sformatf("stretch_cycles%0d@%0d", e.ph, cyc), str_cnt, e.str);
                chk($sformatf("timeout_pulses%0d@%0d", e.ph, cyc), to_cnt, e.to);
                if (open_ph == 3) chk($sformatf("period_done_last@%0d", cyc), pd_cyc, cyc - 1);
            end
            open_ph = -1;
        end
        if (tv != 0 && busy === 1'b1) begin
            idx = tv[1] ? 1 : tv[2] ? 2 : tv[3] ? 3 : 0;
            chk($sformatf("tick_onehot@%0d", cyc), $countones(tv), 1);
            chk($sformatf("phase_out@%0d", cyc), int'(phase), idx);
            chk($sformatf("scl_oe@%0d", cyc), int'(scl_oe), idx < 2 ? 1 : 0);
            open_ph = idx;
            start = cyc;
            str_cnt = 0;
            to_cnt = 0;
        end
        if (open_ph >= 0) begin
            str_cnt += int'(stretching);
            to_cnt += int'(stretch_timeout);
        end
        if (period_done === 1'b1) begin
            pd_cyc = cyc;
            chk($sformatf("period_done_phase@%0d", cyc), open_ph, 3);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int ms[8], cs[8], ss[8];
        int n;
        reset = 1'b1;
        enable = 1'b0;
        mode = 2'd0;
        custom_q = '0;
        for (int i = 0; i < 8; i++) begin
            ms[i] = 0; cs[i] = 0; ss[i] = 0;
        end
        repeat (4) @(negedge clk);
        chk("reset_state", int'({scl_oe, phase, fall_tick, change_tick, rise_tick, sample_tick,
            period_done, busy, stretching, stretch_timeout}), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", int'({scl_oe, busy, fall_tick}), 0);
        // nominal 100 kHz, three periods
        run(3, ms, cs, ss);
        // custom clamp then a new value latched at the next LOW_A
        ms[0] = 3; cs[0] = 1; ms[1] = 3; cs[1] = 5;
        run(2, ms, cs, ss);
        // 40-cycle stretch at Q=10
        ms[0] = 3; cs[0] = 10; ss[0] = 40;
        run(1, ms, cs, ss);
        // timeout boundary: 62 survives, 63 times out
        ss[0] = 62;
        run(1, ms, cs, ss);
        ss[0] = 63;
        run(1, ms, cs, ss);
        // timeout on the second period with SCL stuck low
        cs[0] = 4; ss[0] = 5; ms[1] = 3; cs[1] = 4; ss[1] = 1000;
        run(2, ms, cs, ss);
        reset_test(6);
        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(1, 4);
            for (int i = 0; i < 8; i++) begin
                ms[i] = $urandom_range(1, 3);
                cs[i] = $urandom_range(0, 12);
                ss[i] = $urandom_range(0, 30);
            end
            if ($urandom_range(0, 2) == 0) ss[n - 1] = $urandom_range(55, 80);
            run(n, ms, cs, ss);
        end
        repeat (10) @(negedge clk);
        chk("leftover_expect", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
